// File: rtl/shifter_pkg.sv
// Shared constants and types for the shifter operand-fetch stage.
//   DATA_W / NREGS / AW / SHAMT_W : datapath geometry
//   SHIFT_*                       : shift-type encodings forwarded to the shifter
//   buf_state_t                   : occupancy of the two-entry output buffer
//   entry_t                       : one buffered shifter request
package shifter_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned NREGS   = 16;
   localparam int unsigned AW      = $clog2(NREGS);
   localparam int unsigned SHAMT_W = $clog2(DATA_W);

   localparam logic [1:0] SHIFT_LSL  = 2'b00;
   localparam logic [1:0] SHIFT_LSR  = 2'b01;
   localparam logic [1:0] SHIFT_PASS = 2'b10;

   typedef enum logic [1:0] {
      BufEmpty = 2'd0,
      BufOne   = 2'd1,
      BufTwo   = 2'd2
   } buf_state_t;

   typedef struct packed {
      logic [DATA_W-1:0]  data;
      logic [SHAMT_W-1:0] shamt;
      logic [1:0]         shift_type;
      logic [AW-1:0]      rd;
   } entry_t;

endpackage

// File: rtl/shift_reg_file.sv
// NREGS x DATA_W register file feeding the shifter operand stage.
//   clk, rst              : clock, asynchronous active-high reset (clears all registers)
//   rm_addr / rm_data     : full-width operand read port (combinational)
//   rs_addr / rs_shamt    : shift-amount read port, low SHAMT_W bits only
//   wb_en/wb_addr/wb_data : synchronous write port
// R0 always reads zero and ignores writes. A write in the same cycle as a read of
// the same (non-zero) address is bypassed to the read port.
module shift_reg_file
   import shifter_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [AW-1:0]      rm_addr,
   output logic [DATA_W-1:0]  rm_data,
   input  logic [AW-1:0]      rs_addr,
   output logic [SHAMT_W-1:0] rs_shamt,
   input  logic               wb_en,
   input  logic [AW-1:0]      wb_addr,
   input  logic [DATA_W-1:0]  wb_data
);

   logic [DATA_W-1:0] regs_q [NREGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= '0;
         end
      end else if (wb_en && (wb_addr != '0)) begin
         regs_q[wb_addr] <= wb_data;
      end
   end

   always_comb begin
      rm_data = regs_q[rm_addr];
      if (rm_addr == '0) begin
         rm_data = '0;
      end else if (wb_en && (wb_addr == rm_addr)) begin
         rm_data = wb_data;
      end
   end

   // Only the low bits of Rs ever matter, so the port is narrowed here.
   always_comb begin
      rs_shamt = regs_q[rs_addr][SHAMT_W-1:0];
      if (rs_addr == '0) begin
         rs_shamt = '0;
      end else if (wb_en && (wb_addr == rs_addr)) begin
         rs_shamt = wb_data[SHAMT_W-1:0];
      end
   end

endmodule

// File: rtl/shift_operand_fetch.sv
// Operand-fetch stage directly upstream of the barrel shifter.
//   clk, rst                 : clock, asynchronous active-high reset
//   req_*                    : valid/ready request (Rm, Rs, shamt select/imm, type, rd)
//   wb_en/wb_addr/wb_data    : register-file writeback
//   out_*                    : valid/ready entry to the shifter (data, shamt, type, rd)
// Accepted requests are snapshotted into a two-entry elastic buffer: the output
// register is the head, a skid register holds the second entry so a downstream
// stall never costs a bubble. req_ready depends only on registered state.
module shift_operand_fetch
   import shifter_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [AW-1:0]      req_rm,
   input  logic [AW-1:0]      req_rs,
   input  logic               req_shamt_sel,
   input  logic [SHAMT_W-1:0] req_shamt_imm,
   input  logic [1:0]         req_shift_type,
   input  logic [AW-1:0]      req_rd,
   input  logic               wb_en,
   input  logic [AW-1:0]      wb_addr,
   input  logic [DATA_W-1:0]  wb_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [SHAMT_W-1:0] out_shamt,
   output logic [1:0]         out_shift_type,
   output logic [AW-1:0]      out_rd
);

   buf_state_t state_q, state_d;
   entry_t     head_q, head_d;
   entry_t     skid_q, skid_d;
   entry_t     new_entry;

   logic [DATA_W-1:0]  rm_data;
   logic [SHAMT_W-1:0] rs_shamt;
   logic               accept;
   logic               pop;

   shift_reg_file u_reg_file (
      .clk      (clk),
      .rst      (rst),
      .rm_addr  (req_rm),
      .rm_data  (rm_data),
      .rs_addr  (req_rs),
      .rs_shamt (rs_shamt),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data)
   );

   always_comb begin
      new_entry.data       = rm_data;
      new_entry.shamt      = req_shamt_sel ? rs_shamt : req_shamt_imm;
      new_entry.shift_type = req_shift_type;
      new_entry.rd         = req_rd;
   end

   assign req_ready = !rst && (state_q != BufTwo);
   assign out_valid = (state_q != BufEmpty);
   assign accept    = req_valid && req_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      unique case (state_q)
         BufEmpty: begin
            if (accept) begin
               head_d  = new_entry;
               state_d = BufOne;
            end
         end
         BufOne: begin
            if (accept && pop) begin
               head_d = new_entry;
            end else if (accept) begin
               skid_d  = new_entry;
               state_d = BufTwo;
            end else if (pop) begin
               state_d = BufEmpty;
            end
         end
         BufTwo: begin
            // req_ready is low here, so only a pop can happen.
            if (pop) begin
               head_d  = skid_q;
               state_d = BufOne;
            end
         end
         default: state_d = BufEmpty;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BufEmpty;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

   assign out_data       = head_q.data;
   assign out_shamt      = head_q.shamt;
   assign out_shift_type = head_q.shift_type;
   assign out_rd         = head_q.rd;

endmodule

// File: tb/tb_shift_operand_fetch.sv
// Self-checking bench for shift_operand_fetch: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_shift_operand_fetch;
   import shifter_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_rm = '0;
   logic [3:0]  req_rs = '0;
   logic        req_shamt_sel = 1'b0;
   logic [4:0]  req_shamt_imm = '0;
   logic [1:0]  req_shift_type = '0;
   logic [3:0]  req_rd = '0;
   logic        wb_en = 1'b0;
   logic [3:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [4:0]  out_shamt;
   logic [1:0]  out_shift_type;
   logic [3:0]  out_rd;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  shamt;
      logic [1:0]  st;
      logic [3:0]  rd;
   } exp_t;

   logic [31:0] reg_m [16];
   exp_t        exp_q [$];

   always #5 clk = ~clk;

   shift_operand_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_rm         (req_rm),
      .req_rs         (req_rs),
      .req_shamt_sel  (req_shamt_sel),
      .req_shamt_imm  (req_shamt_imm),
      .req_shift_type (req_shift_type),
      .req_rd         (req_rd),
      .wb_en          (wb_en),
      .wb_addr        (wb_addr),
      .wb_data        (wb_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_shamt      (out_shamt),
      .out_shift_type (out_shift_type),
      .out_rd         (out_rd)
   );

   // Register value as seen by a read this cycle (R0 zero, same-cycle write wins).
   function automatic logic [31:0] model_read(input logic [3:0] a);
      if (a == 4'd0) return 32'd0;
      if (wb_en && (wb_addr == a)) return wb_data;
      return reg_m[a];
   endfunction

   // Clock one cycle and advance the reference model: FIFO of at most two entries.
   task automatic advance();
      bit          acc;
      bit          pp;
      exp_t        e;
      logic [31:0] rsv;
      acc = req_valid && !rst && (exp_q.size() < 2);
      pp  = (exp_q.size() != 0) && out_ready;
      e   = '{default: '0};
      if (acc) begin
         rsv     = model_read(req_rs);
         e.data  = model_read(req_rm);
         e.shamt = req_shamt_sel ? rsv[4:0] : req_shamt_imm;
         e.st    = req_shift_type;
         e.rd    = req_rd;
      end
      @(posedge clk);
      if (pp) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(e);
      if (wb_en && (wb_addr != 4'd0)) reg_m[wb_addr] = wb_data;
      #1;
   endtask

   task automatic idle_inputs();
      req_valid     = 1'b0;
      wb_en         = 1'b0;
      req_shamt_sel = 1'b0;
      req_rs        = '0;
   endtask

   task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
      req_valid = 1'b0;
      wb_en     = 1'b1;
      wb_addr   = a;
      wb_data   = d;
      advance();
      wb_en = 1'b0;
   endtask

   task automatic set_req(input logic [3:0] rm, input logic [3:0] rs, input logic sel,
                          input logic [4:0] imm, input logic [1:0] st, input logic [3:0] rd);
      req_valid      = 1'b1;
      req_rm         = rm;
      req_rs         = rs;
      req_shamt_sel  = sel;
      req_shamt_imm  = imm;
      req_shift_type = st;
      req_rd         = rd;
   endtask

   task automatic drain();
      idle_inputs();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() == 0) break;
         advance();
      end
      total++;
      if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL drain out_valid=%b model_entries=%0d required empty", out_valid,
                  exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) reg_m[i] = '0;
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL reset_out_valid actual=%b required=0", out_valid);
      end
      total++;
      if (req_ready !== 1'b0) begin
         bad++; $display("FAIL reset_req_ready actual=%b required=0", req_ready);
      end
      total++;
      if ({out_data, out_shamt, out_shift_type, out_rd} !== 43'd0) begin
         bad++;
         $display("FAIL reset_out_fields actual=%h/%h/%h/%h required=0", out_data, out_shamt,
                  out_shift_type, out_rd);
      end
      rst = 1'b0;
      advance();
      // Fill registers and the buffer, then reset in the middle of traffic.
      for (int i = 1; i < 16; i++) write_reg(4'(i), $urandom() | 32'h1);
      out_ready = 1'b0;
      set_req(4'd1, 4'd0, 1'b0, 5'd1, SHIFT_LSL, 4'd1);
      advance();
      set_req(4'd2, 4'd0, 1'b0, 5'd2, SHIFT_LSR, 4'd2);
      advance();
      rst = 1'b1;
      #1;
      total++;
      if (out_valid !== 1'b0 || req_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid valid=%b ready=%b required 0/0", out_valid, req_ready);
      end
      exp_q.delete();
      for (int i = 0; i < 16; i++) reg_m[i] = '0;
      idle_inputs();
      advance();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 1; i < 16; i++) begin
         set_req(4'(i), 4'd0, 1'b0, 5'd0, SHIFT_PASS, 4'(i));
         advance();
         total++;
         if (out_valid !== 1'b1 || out_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_cleared_r%0d valid=%b data=%h required 1/00000000", i,
                     out_valid, out_data);
         end
      end
      drain();
   endtask

   task automatic test_basic();
      write_reg(4'd3, 32'h0000_00F0);
      out_ready = 1'b1;
      set_req(4'd3, 4'd0, 1'b0, 5'd4, SHIFT_LSL, 4'd9);
      advance();
      idle_inputs();
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000_00F0 || out_shamt !== 5'd4 ||
          out_shift_type !== 2'b00 || out_rd !== 4'd9) begin
         bad++;
         $display("FAIL basic actual v=%b d=%h s=%0d t=%b rd=%0d required 1/000000f0/4/00/9",
                  out_valid, out_data, out_shamt, out_shift_type, out_rd);
      end
      drain();
   endtask

   task automatic test_bypass();
      out_ready = 1'b1;
      wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'hDEAD_BEEF;
      set_req(4'd5, 4'd0, 1'b0, 5'd0, SHIFT_LSR, 4'd1);
      advance();
      idle_inputs();
      total++;
      if (out_data !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL bypass_rm actual=%h required=deadbeef", out_data);
      end
      wb_en = 1'b1; wb_addr = 4'd0; wb_data = 32'h0000_1234;
      set_req(4'd0, 4'd0, 1'b0, 5'd0, SHIFT_LSL, 4'd2);
      advance();
      idle_inputs();
      total++;
      if (out_data !== 32'd0) begin
         bad++; $display("FAIL bypass_r0 actual=%h required=00000000", out_data);
      end
      set_req(4'd5, 4'd0, 1'b0, 5'd0, SHIFT_LSL, 4'd3);
      advance();
      idle_inputs();
      total++;
      if (out_data !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL bypass_written actual=%h required=deadbeef", out_data);
      end
      wb_en = 1'b1; wb_addr = 4'd9; wb_data = 32'h0000_001A;
      set_req(4'd0, 4'd9, 1'b1, 5'd0, SHIFT_LSL, 4'd4);
      advance();
      idle_inputs();
      total++;
      if (out_shamt !== 5'd26) begin
         bad++; $display("FAIL bypass_rs actual=%0d required=26", out_shamt);
      end
      drain();
   endtask

   task automatic test_reg_shamt();
      write_reg(4'd7, 32'hFFFF_FFE3);
      out_ready = 1'b1;
      set_req(4'd7, 4'd7, 1'b1, 5'd31, SHIFT_LSR, 4'd7);
      advance();
      idle_inputs();
      total++;
      if (out_shamt !== 5'd3 || out_data !== 32'hFFFF_FFE3) begin
         bad++;
         $display("FAIL reg_shamt actual s=%0d d=%h required 3/ffffffe3", out_shamt, out_data);
      end
      drain();
   endtask

   task automatic test_backpressure();
      write_reg(4'd1, 32'hAAAA_0001);
      write_reg(4'd2, 32'hBBBB_0002);
      write_reg(4'd4, 32'hCCCC_0004);
      out_ready = 1'b0;
      set_req(4'd1, 4'd0, 1'b0, 5'd1, SHIFT_LSL, 4'd1);
      total++;
      if (req_ready !== 1'b1) begin
         bad++; $display("FAIL bp_ready_empty actual=%b required=1", req_ready);
      end
      advance();
      set_req(4'd2, 4'd0, 1'b0, 5'd2, SHIFT_LSR, 4'd2);
      total++;
      if (req_ready !== 1'b1) begin
         bad++; $display("FAIL bp_ready_one actual=%b required=1", req_ready);
      end
      advance();
      set_req(4'd4, 4'd0, 1'b0, 5'd3, SHIFT_PASS, 4'd3);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (req_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hAAAA_0001 ||
             out_shamt !== 5'd1 || out_rd !== 4'd1) begin
            bad++;
            $display("FAIL bp_stall%0d ready=%b v=%b d=%h s=%0d rd=%0d required 0/1/aaaa0001/1/1",
                     i, req_ready, out_valid, out_data, out_shamt, out_rd);
         end
         advance();
      end
      out_ready = 1'b1;
      total++;
      if (out_data !== 32'hAAAA_0001) begin
         bad++; $display("FAIL bp_first actual=%h required=aaaa0001", out_data);
      end
      advance();
      total++;
      if (out_data !== 32'hBBBB_0002 || out_rd !== 4'd2 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL bp_second d=%h rd=%0d ready=%b required bbbb0002/2/1", out_data,
                  out_rd, req_ready);
      end
      advance();
      idle_inputs();
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'hCCCC_0004 || out_rd !== 4'd3 ||
          out_shift_type !== SHIFT_PASS) begin
         bad++;
         $display("FAIL bp_third v=%b d=%h rd=%0d t=%b required 1/cccc0004/3/10", out_valid,
                  out_data, out_rd, out_shift_type);
      end
      advance();
      total++;
      if (out_valid !== 1'b0) begin
         bad++; $display("FAIL bp_empty actual=%b required=0", out_valid);
      end
      drain();
   endtask

   task automatic rand_req(input int valid_pct);
      req_valid      = ($urandom_range(99) < valid_pct);
      req_rm         = 4'($urandom_range(15));
      req_rs         = 4'($urandom_range(15));
      req_shamt_sel  = 1'($urandom_range(1));
      req_shamt_imm  = 5'($urandom_range(31));
      req_shift_type = 2'($urandom_range(3));
      req_rd         = 4'($urandom_range(15));
      wb_en          = ($urandom_range(3) == 0);
      wb_addr        = 4'($urandom_range(15));
      wb_data        = $urandom();
   endtask

   task automatic test_throughput();
      int outs;
      outs = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         rand_req(100);
         total++;
         if (req_ready !== 1'b1) begin
            bad++; $display("FAIL tput_ready cycle=%0d actual=%b required=1", i, req_ready);
         end
         if (i > 0) begin
            total++;
            if (out_valid !== 1'b1) begin
               bad++; $display("FAIL tput_bubble cycle=%0d actual=%b required=1", i, out_valid);
            end
         end
         if (out_valid === 1'b1 && exp_q.size() != 0) begin
            outs++;
            total++;
            if ({out_data, out_shamt, out_shift_type, out_rd} !==
                {exp_q[0].data, exp_q[0].shamt, exp_q[0].st, exp_q[0].rd}) begin
               bad++;
               $display("FAIL tput_entry cycle=%0d actual=%h/%0d/%b/%0d required=%h/%0d/%b/%0d",
                        i, out_data, out_shamt, out_shift_type, out_rd, exp_q[0].data,
                        exp_q[0].shamt, exp_q[0].st, exp_q[0].rd);
            end
         end
         advance();
      end
      idle_inputs();
      if (out_valid === 1'b1 && exp_q.size() != 0) begin
         outs++;
         total++;
         if (out_data !== exp_q[0].data || out_rd !== exp_q[0].rd) begin
            bad++;
            $display("FAIL tput_last actual=%h/%0d required=%h/%0d", out_data, out_rd,
                     exp_q[0].data, exp_q[0].rd);
         end
      end
      advance();
      total++;
      if (outs != 100) begin
         bad++; $display("FAIL tput_count actual=%0d required=100", outs);
      end
      drain();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rand_req(60);
         out_ready = ($urandom_range(1) == 1);
         total++;
         if (req_ready !== (exp_q.size() < 2) || out_valid !== (exp_q.size() != 0)) begin
            bad++;
            $display("FAIL rand_ctrl cycle=%0d ready=%b valid=%b required %b/%b", i, req_ready,
                     out_valid, exp_q.size() < 2, exp_q.size() != 0);
         end
         if (exp_q.size() != 0) begin
            total++;
            if ({out_data, out_shamt, out_shift_type, out_rd} !==
                {exp_q[0].data, exp_q[0].shamt, exp_q[0].st, exp_q[0].rd}) begin
               bad++;
               $display("FAIL rand_entry cycle=%0d actual=%h/%0d/%b/%0d required=%h/%0d/%b/%0d",
                        i, out_data, out_shamt, out_shift_type, out_rd, exp_q[0].data,
                        exp_q[0].shamt, exp_q[0].st, exp_q[0].rd);
            end
         end
         advance();
      end
      drain();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_bypass();
      test_reg_shamt();
      test_backpressure();
      test_throughput();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
